vpe_slave_mux: RTL and testbench

Parametrised variable processing element for the SAT array. It holds N_CLAUSE clause-literal entries for one variable and scans them LANES at a time. During the scan it accumulates weighted up/down votes and a local clause-satisfaction flag, then updates the variable value deterministically or by LFSR tie-break. It replaces the fixed 32-clause, fully combinational slave with a time-multiplexed, start/done-controlled column that chains into the systolic satisfy network.

---
 rtl/vpe_slave_mux.sv | 183 ++++++++++++++++++
 tb/tb_vpe_slave_mux.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vpe_slave_mux.sv
// Variable processing element for the SAT array. It scans N_CLAUSE clause entries LANES at a time,
// accumulates up/down votes and a satisfaction flag, then updates VI.
// Optional build macro VPE_LFSR_TIEBREAK_EN adds an LFSR tie-break driven by STOCHASTIC_MODE.
module vpe_slave_mux #(
    parameter int          N_CLAUSE  = 32,
    parameter int          LANES     = 8,
    parameter int          SW        = $clog2(N_CLAUSE + 1),
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic                        WR_EN,
    input  logic [$clog2(N_CLAUSE)-1:0] WR_ADDR,
    input  logic                        WR_P,
    input  logic                        WR_S,
    input  logic [N_CLAUSE-1:0]         UNSAT,
    input  logic                        START,
    input  logic                        PRELOAD,
    input  logic                        V_PRE,
    input  logic                        STOCHASTIC_MODE,
    input  logic                        SATISFY_UP,
    input  logic                        SATISFY_LEFT,
    input  logic                        MERGE,
    output logic                        BUSY,
    output logic                        DONE,
    output logic                        WR_ERR,
    output logic                        VI,
    output logic [SW-1:0]               SUM_UP,
    output logic [SW-1:0]               SUM_DOWN,
    output logic                        SATISFY
);

    localparam int G  = N_CLAUSE / LANES;
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_DECIDE = 2'd2
    } state_t;

    state_t              r_state;
    logic [GW-1:0]       r_group;
    logic [N_CLAUSE-1:0] r_p;
    logic [N_CLAUSE-1:0] r_s;
    logic [SW-1:0]       r_acc_up;
    logic [SW-1:0]       r_acc_dn;
    logic                r_acc_sat;
    logic [SW-1:0]       r_sum_up;
    logic [SW-1:0]       r_sum_dn;
    logic                r_sat;
    logic                r_vi;
    logic                r_busy;
    logic                r_done;
    logic                r_wr_err;

    logic [LANES-1:0]    w_p_grp;
    logic [LANES-1:0]    w_s_grp;
    logic [LANES-1:0]    w_u_grp;
    logic [LANES-1:0]    w_up_hit;
    logic [LANES-1:0]    w_dn_hit;
    logic [LANES-1:0]    w_lane_ok;
    logic [SW-1:0]       w_up_cnt;
    logic [SW-1:0]       w_dn_cnt;
    logic                w_tie_vi;

    assign w_p_grp = r_p[int'(r_group) * LANES +: LANES];
    assign w_s_grp = r_s[int'(r_group) * LANES +: LANES];
    assign w_u_grp = UNSAT[int'(r_group) * LANES +: LANES];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_up_hit[gi]  = w_p_grp[gi] & w_s_grp[gi] & w_u_grp[gi];
        assign w_dn_hit[gi]  = w_p_grp[gi] & ~w_s_grp[gi] & w_u_grp[gi];
        assign w_lane_ok[gi] = ~w_p_grp[gi] | (w_s_grp[gi] == r_vi);
    end

    always_comb begin
        w_up_cnt = '0;
        w_dn_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            w_up_cnt = w_up_cnt + SW'(w_up_hit[i]);
            w_dn_cnt = w_dn_cnt + SW'(w_dn_hit[i]);
        end
    end

`ifdef VPE_LFSR_TIEBREAK_EN
    // Fibonacci LFSR, taps 16,14,13,11 in shift-right form
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;
    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_tie_vi  = STOCHASTIC_MODE ? r_lfsr[0] : r_vi;
`else
    logic w_unused_stochastic;
    assign w_unused_stochastic = STOCHASTIC_MODE;
    assign w_tie_vi = r_vi;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= S_IDLE;
            r_group   <= '0;
            r_p       <= '0;
            r_s       <= '0;
            r_acc_up  <= '0;
            r_acc_dn  <= '0;
            r_acc_sat <= 1'b0;
            r_sum_up  <= '0;
            r_sum_dn  <= '0;
            r_sat     <= 1'b0;
            r_vi      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr_err  <= 1'b0;
`ifdef VPE_LFSR_TIEBREAK_EN
            r_lfsr    <= LFSR_SEED;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_state   <= S_ACCUM;
                        r_group   <= '0;
                        r_acc_up  <= '0;
                        r_acc_dn  <= '0;
                        r_acc_sat <= 1'b1;
                        r_busy    <= 1'b1;
                    end else if (PRELOAD) begin
                        r_vi <= V_PRE;
                    end
                    if (WR_EN) begin
                        r_p[WR_ADDR] <= WR_P;
                        r_s[WR_ADDR] <= WR_S;
                    end
                end
                S_ACCUM: begin
                    r_acc_up  <= r_acc_up + w_up_cnt;
                    r_acc_dn  <= r_acc_dn + w_dn_cnt;
                    r_acc_sat <= r_acc_sat & (&w_lane_ok);
                    r_group   <= r_group + 1'b1;
                    if (int'(r_group) == G - 1) begin
                        r_state <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    r_sum_up <= r_acc_up;
                    r_sum_dn <= r_acc_dn;
                    r_sat    <= r_acc_sat;
                    if (r_acc_up > r_acc_dn) begin
                        r_vi <= 1'b1;
                    end else if (r_acc_up < r_acc_dn) begin
                        r_vi <= 1'b0;
                    end else begin
                        r_vi <= w_tie_vi;
                    end
`ifdef VPE_LFSR_TIEBREAK_EN
                    r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
`endif
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            // Writes during a scan are dropped so the scanned data stays coherent
            if (WR_EN && (r_state != S_IDLE)) begin
                r_wr_err <= 1'b1;
            end
        end
    end

    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign WR_ERR   = r_wr_err;
    assign VI       = r_vi;
    assign SUM_UP   = r_sum_up;
    assign SUM_DOWN = r_sum_dn;
    assign SATISFY  = MERGE | (r_sat & SATISFY_UP & SATISFY_LEFT);

endmodule

// File: tb/tb_vpe_slave_mux.sv
// Directed bench for vpe_slave_mux: a clause model predicts each scan result, which is queued
// at START and compared when DONE pulses.
module tb_vpe_slave_mux;
    localparam int N  = 32;
    localparam int L  = 8;
    localparam int SW = 6;
    localparam int LAT = N / L + 1;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          WR_EN = 1'b0;
    logic [4:0]    WR_ADDR = '0;
    logic          WR_P = 1'b0;
    logic          WR_S = 1'b0;
    logic [N-1:0]  UNSAT = '0;
    logic          START = 1'b0;
    logic          PRELOAD = 1'b0;
    logic          V_PRE = 1'b0;
    logic          STOCHASTIC_MODE = 1'b0;
    logic          SATISFY_UP = 1'b1;
    logic          SATISFY_LEFT = 1'b1;
    logic          MERGE = 1'b0;
    logic          BUSY, DONE, WR_ERR, VI, SATISFY;
    logic [SW-1:0] SUM_UP, SUM_DOWN;

    vpe_slave_mux #(.N_CLAUSE(N), .LANES(L)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_P(WR_P),
        .WR_S(WR_S), .UNSAT(UNSAT), .START(START), .PRELOAD(PRELOAD), .V_PRE(V_PRE),
        .STOCHASTIC_MODE(STOCHASTIC_MODE), .SATISFY_UP(SATISFY_UP),
        .SATISFY_LEFT(SATISFY_LEFT), .MERGE(MERGE), .BUSY(BUSY), .DONE(DONE),
        .WR_ERR(WR_ERR), .VI(VI), .SUM_UP(SUM_UP), .SUM_DOWN(SUM_DOWN), .SATISFY(SATISFY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [SW-1:0] up;
        logic [SW-1:0] dn;
        logic          vi;
        logic          sat;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           failures = 0;
    logic [N-1:0] m_p = '0;
    logic [N-1:0] m_s = '0;
    logic         m_vi = 1'b0;
    logic [15:0]  m_lfsr = 16'hACE1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_clause(input int a, input logic p, input logic s);
        WR_ADDR = 5'(a); WR_P = p; WR_S = s; WR_EN = 1'b1;
        tick();
        WR_EN = 1'b0;
        m_p[a] = p;
        m_s[a] = s;
        $display("write addr=%0d p=%0d s=%0d", a, p, s);
    endtask

    task automatic clear_clauses();
        for (int i = 0; i < N; i++) write_clause(i, 1'b0, 1'b0);
    endtask

    task automatic preload(input logic v);
        V_PRE = v; PRELOAD = 1'b1;
        tick();
        PRELOAD = 1'b0;
        m_vi = v;
        check("preload_vi", 32'(VI), 32'(v));
    endtask

    task automatic push_expected(input logic [N-1:0] u, input logic stoch);
        exp_t e;
        int up = 0;
        int dn = 0;
        e.sat = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (m_p[i] && u[i]) begin
                if (m_s[i]) up++; else dn++;
            end
            if (m_p[i] && (m_s[i] != m_vi)) e.sat = 1'b0;
        end
        e.up = SW'(up);
        e.dn = SW'(dn);
        if (up > dn)      e.vi = 1'b1;
        else if (up < dn) e.vi = 1'b0;
        else begin
`ifdef VPE_LFSR_TIEBREAK_EN
            e.vi = stoch ? m_lfsr[0] : m_vi;
`else
            e.vi = m_vi;
`endif
        end
`ifdef VPE_LFSR_TIEBREAK_EN
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
        m_vi = e.vi;
        sb.push_back(e);
    endtask

    // mode 1: illegal write two cycles after START and a second START while busy
    task automatic run_scan(input string tag, input logic [N-1:0] u, input logic stoch, input int mode);
        int   cyc = 0;
        int   extra = 0;
        exp_t e;
        UNSAT = u; STOCHASTIC_MODE = stoch;
        push_expected(u, stoch);
        START = 1'b1;
        tick();
        START = 1'b0;
        check({tag, "_busy"}, 32'(BUSY), 32'd1);
        while (cyc < 20) begin
            tick();
            cyc++;
            if (DONE === 1'b1) break;
            if (mode == 1 && cyc == 1) begin
                WR_ADDR = 5'd30; WR_P = 1'b1; WR_S = 1'b0; WR_EN = 1'b1;
            end
            if (mode == 1 && cyc == 2) begin
                WR_EN = 1'b0; START = 1'b1;
            end
            if (mode == 1 && cyc == 3) START = 1'b0;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(LAT));
        check({tag, "_busy_at_done"}, 32'(BUSY), 32'd0);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_sum_up"}, 32'(SUM_UP), 32'(e.up));
            check({tag, "_sum_down"}, 32'(SUM_DOWN), 32'(e.dn));
            check({tag, "_vi"}, 32'(VI), 32'(e.vi));
            check({tag, "_satisfy"}, 32'(SATISFY), 32'(e.sat));
            $display("scan %s up=%0d dn=%0d vi=%0d sat=%0d cycles=%0d", tag, SUM_UP, SUM_DOWN, VI, SATISFY, cyc);
        end
        tick();
        check({tag, "_done_pulse"}, 32'(DONE), 32'd0);
        if (mode == 1) begin
            for (int i = 0; i < 8; i++) begin
                if (DONE === 1'b1) extra++;
                tick();
            end
            check({tag, "_extra_done"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick();
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_vi", 32'(VI), 32'd0);
        check("rst_sum_up", 32'(SUM_UP), 32'd0);
        check("rst_sum_down", 32'(SUM_DOWN), 32'd0);
        check("rst_wr_err", 32'(WR_ERR), 32'd0);
        check("rst_satisfy", 32'(SATISFY), 32'd0);
        RESET_N = 1'b1;
        tick();

        // 6 up / 2 down with everything unsatisfied
        for (int i = 0; i < 6; i++) write_clause(i, 1'b1, 1'b1);
        for (int i = 6; i < 8; i++) write_clause(i, 1'b1, 1'b0);
        run_scan("vote_up", '1, 1'b0, 0);

        // Only the negative literals unsatisfied; preload 1 is overridden by the vote
        preload(1'b1);
        run_scan("vote_down", 32'h0000_00C0, 1'b0, 0);

        // 3 / 3 tie holds VI, then the stochastic tie
        clear_clauses();
        for (int i = 0; i < 3; i++) write_clause(i, 1'b1, 1'b1);
        for (int i = 3; i < 6; i++) write_clause(i, 1'b1, 1'b0);
        preload(1'b1);
        run_scan("tie_hold", '1, 1'b0, 0);
        preload(~m_lfsr[0]);
        run_scan("tie_stoch", '1, 1'b1, 0);

        // Every present literal agrees with VI=0
        clear_clauses();
        for (int i = 0; i < 4; i++) write_clause(i, 1'b1, 1'b0);
        write_clause(20, 1'b1, 1'b0);
        preload(1'b0);
        run_scan("sat_all", '0, 1'b0, 0);
        SATISFY_LEFT = 1'b0;
        #1 check("sat_left_drop", 32'(SATISFY), 32'd0);
        MERGE = 1'b1;
        #1 check("sat_merge", 32'(SATISFY), 32'd1);
        MERGE = 1'b0; SATISFY_LEFT = 1'b1;
        tick();

        // Write and START while busy are dropped
        for (int i = 8; i < 14; i++) write_clause(i, 1'b1, 1'b1);
        run_scan("busy_write", '1, 1'b0, 1);
        check("wr_err_set", 32'(WR_ERR), 32'd1);
        run_scan("readback", '1, 1'b0, 0);
        check("wr_err_sticky", 32'(WR_ERR), 32'd1);

        // Reset two cycles into the scan
        UNSAT = '1;
        START = 1'b1;
        tick();
        START = 1'b0;
        tick(); tick();
        RESET_N = 1'b0;
        m_p = '0; m_s = '0; m_vi = 1'b0; m_lfsr = 16'hACE1;
        #1;
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_vi", 32'(VI), 32'd0);
        check("abort_sum_up", 32'(SUM_UP), 32'd0);
        check("abort_sum_down", 32'(SUM_DOWN), 32'd0);
        check("abort_wr_err", 32'(WR_ERR), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 3) RESET_N = 1'b1;
            check("abort_no_done", 32'(DONE), 32'd0);
        end
        $display("reset abort checked");

        for (int i = 0; i < 6; i++) write_clause(i, 1'b1, 1'b1);
        for (int i = 6; i < 8; i++) write_clause(i, 1'b1, 1'b0);
        run_scan("post_reset", '1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
